// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Issue side of the ALU one-hot interface. Accepts one encoded
//            instruction at a time over valid/ready, reads both operands from
//            an internal register file, drives the ALU with operands and a
//            one-hot operation, captures the ALU's combinational result and
//            writes it back with a one-cycle writeback strobe.
//            Sequence: IDLE (accept) -> EXEC (drive ALU) -> WB (write back).
// Ports    : iClock, iReset      - clock, synchronous active-high reset
//            iInstValid/oInstReady, iInstOpcode/Dst/SrcA/SrcB - instruction
//            iRegWrEn/Addr/Data  - host register preload (IDLE only)
//            oAluOperandA/B, oAluOperation, iAluResult - ALU interface
//            oWbValid/Addr/Data  - writeback report
//            oCmpFlag            - only with ALU_ISSUE_CMP_FLAG_EN defined
// Config   : ALU_ISSUE_CMP_FLAG_EN - adds the sticky CMP result flag output
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iInstValid,
  output logic                  oInstReady,
  input  logic [2:0]            iInstOpcode,
  input  logic [REG_ADDR_W-1:0] iInstDst,
  input  logic [REG_ADDR_W-1:0] iInstSrcA,
  input  logic [REG_ADDR_W-1:0] iInstSrcB,
  input  logic                  iRegWrEn,
  input  logic [REG_ADDR_W-1:0] iRegWrAddr,
  input  logic [DATA_W-1:0]     iRegWrData,
  output logic [DATA_W-1:0]     oAluOperandA,
  output logic [DATA_W-1:0]     oAluOperandB,
  output logic [7:0]            oAluOperation,
  input  logic [DATA_W-1:0]     iAluResult,
  output logic                  oWbValid,
  output logic [REG_ADDR_W-1:0] oWbAddr,
  output logic [DATA_W-1:0]     oWbData
`ifdef ALU_ISSUE_CMP_FLAG_EN
  ,
  output logic                  oCmpFlag
`endif
);

  localparam int         NUM_REGS = 1 << REG_ADDR_W;
  localparam logic [2:0] OP_CMP   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [2:0]            opcode_lat;
  logic [REG_ADDR_W-1:0] dst_lat;
  logic [REG_ADDR_W-1:0] src_a_lat;
  logic [REG_ADDR_W-1:0] src_b_lat;
  logic [DATA_W-1:0]     result;

  // Packed storage so the whole file clears in one reset assignment.
  // Entry 0 is never written, so it always reads as zero.
  logic [NUM_REGS-1:0][DATA_W-1:0] rf;

  logic                  accept;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;

  assign accept = (state == ST_IDLE) && iInstValid;

  // FSM state register
  always_ff @(posedge iClock) begin
    if (iReset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and all state-decoded outputs. ALU lines are zero outside
  // EXEC so the ALU sits on a FALSE result between instructions.
  always_comb begin
    state_nxt     = state;
    oInstReady    = 1'b0;
    oAluOperandA  = '0;
    oAluOperandB  = '0;
    oAluOperation = 8'h00;
    oWbValid      = 1'b0;
    oWbAddr       = '0;
    oWbData       = '0;
    case (state)
      ST_IDLE: begin
        oInstReady = 1'b1;
        if (iInstValid) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        oAluOperandA  = rf[src_a_lat];
        oAluOperandB  = rf[src_b_lat];
        oAluOperation = 8'h01 << opcode_lat;
        state_nxt     = ST_WB;
      end
      ST_WB: begin
        oWbValid  = 1'b1;
        oWbAddr   = dst_lat;
        oWbData   = result;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Instruction latch and result capture
  always_ff @(posedge iClock) begin
    if (iReset) begin
      opcode_lat <= '0;
      dst_lat    <= '0;
      src_a_lat  <= '0;
      src_b_lat  <= '0;
      result     <= '0;
    end else begin
      if (accept) begin
        opcode_lat <= iInstOpcode;
        dst_lat    <= iInstDst;
        src_a_lat  <= iInstSrcA;
        src_b_lat  <= iInstSrcB;
      end
      if (state == ST_EXEC) result <= iAluResult;
    end
  end

  // Register file write port. WB and preload are mutually exclusive by
  // state. A preload in the accept cycle lands before EXEC reads operands,
  // so the accepted instruction sees the new value.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (state == ST_WB) begin
      rf_we    = (dst_lat != '0);
      rf_waddr = dst_lat;
      rf_wdata = result;
    end else if ((state == ST_IDLE) && iRegWrEn) begin
      rf_we    = (iRegWrAddr != '0);
      rf_waddr = iRegWrAddr;
      rf_wdata = iRegWrData;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset)     rf           <= '0;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

`ifdef ALU_ISSUE_CMP_FLAG_EN
  // Sticky: only a CMP writeback changes it.
  always_ff @(posedge iClock) begin
    if (iReset)                                       oCmpFlag <= 1'b0;
    else if ((state == ST_WB) && (opcode_lat == OP_CMP)) oCmpFlag <= result[0];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Self-checking bench for alu_issue_ctrl. A behavioural ALU closes
//            the loop; expected writebacks come from a reference register
//            file and are queued at accept time, then compared on oWbValid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  localparam logic [2:0] OP_ADD = 3'd0, OP_AND = 3'd1, OP_OR  = 3'd2,
                         OP_NOT = 3'd3, OP_XOR = 3'd4, OP_SL  = 3'd5,
                         OP_SR  = 3'd6, OP_CMP = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [2:0]  inst_op, inst_dst, inst_sa, inst_sb;
  logic        reg_we;
  logic [2:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic [15:0] alu_a, alu_b, alu_res;
  logic [7:0]  alu_op;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
`ifdef ALU_ISSUE_CMP_FLAG_EN
  logic        cmp_flag;
`endif

  alu_issue_ctrl #(.DATA_W(16), .REG_ADDR_W(3)) dut (
    .iClock       (clk),
    .iReset       (rst),
    .iInstValid   (inst_valid),
    .oInstReady   (inst_ready),
    .iInstOpcode  (inst_op),
    .iInstDst     (inst_dst),
    .iInstSrcA    (inst_sa),
    .iInstSrcB    (inst_sb),
    .iRegWrEn     (reg_we),
    .iRegWrAddr   (reg_waddr),
    .iRegWrData   (reg_wdata),
    .oAluOperandA (alu_a),
    .oAluOperandB (alu_b),
    .oAluOperation(alu_op),
    .iAluResult   (alu_res),
    .oWbValid     (wb_valid),
    .oWbAddr      (wb_addr),
    .oWbData      (wb_data)
`ifdef ALU_ISSUE_CMP_FLAG_EN
    ,
    .oCmpFlag     (cmp_flag)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural one-hot ALU, combinational
  always_comb begin
    alu_res = 16'h0000;
    case (alu_op)
      8'h01: alu_res = alu_a + alu_b;
      8'h02: alu_res = alu_a & alu_b;
      8'h04: alu_res = alu_a | alu_b;
      8'h08: alu_res = ~alu_a;
      8'h10: alu_res = alu_a ^ alu_b;
      8'h20: alu_res = alu_a << alu_b;
      8'h40: alu_res = alu_a >> alu_b;
      8'h80: alu_res = (alu_a == alu_b) ? 16'h0001 : 16'h0000;
      default: alu_res = 16'h0000;
    endcase
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [15:0] mrf [8];
  logic [7:0]  oh_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  logic [2:0]  last_op;
  logic [15:0] last_a, last_b;

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      OP_ADD: return a + b;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_NOT: return ~a;
      OP_XOR: return a ^ b;
      OP_SL:  return (b >= 16) ? 16'h0000 : 16'(a << b[3:0]);
      OP_SR:  return (b >= 16) ? 16'h0000 : 16'(a >> b[3:0]);
      default: return (a == b) ? 16'h0001 : 16'h0000;
    endcase
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (wb_valid) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("wb_addr",  wb_addr, e.addr);
        check("wb_data",  wb_data, e.data);
        check("wb_cycle", cyc, e.cyc + 2);
      end
    end
  end

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    reg_we = 1'b1; reg_waddr = a; reg_wdata = d;
    if (inst_ready && a != 3'd0) mrf[a] = d;
    @(posedge clk);
    #1 reg_we = 1'b0;
  endtask

  // Offer an instruction (optionally with a same-cycle preload); returns
  // right after the accepting edge with iInstValid still high.
  task automatic issue(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] sa,
                       input logic [2:0] sbr, input bit pre_en, input logic [2:0] pa,
                       input logic [15:0] pd);
    int   waits;
    exp_t e;
    waits = 0;
    @(negedge clk);
    while (!inst_ready && waits < 10) begin
      waits++;
      @(negedge clk);
    end
    if (!inst_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      inst_valid = 1'b0;
      return;
    end
    if (pre_en) begin
      reg_we = 1'b1; reg_waddr = pa; reg_wdata = pd;
      if (pa != 3'd0) mrf[pa] = pd;
    end
    inst_valid = 1'b1; inst_op = op; inst_dst = dst; inst_sa = sa; inst_sb = sbr;
    last_op = op; last_a = mrf[sa]; last_b = mrf[sbr];
    e.addr = dst;
    e.data = ref_alu(op, mrf[sa], mrf[sbr]);
    e.cyc  = cyc;
    sb.push_back(e);
    if (dst != 3'd0) mrf[dst] = e.data;
    @(posedge clk);
    #1 reg_we = 1'b0;
  endtask

  task automatic exec_check();
    @(negedge clk);
    check("exec_onehot", alu_op, oh_tab[last_op]);
    check("exec_opa",    alu_a,  last_a);
    check("exec_opb",    alu_b,  last_b);
    check("exec_ready",  inst_ready, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!inst_ready && n < 10);
    if (!inst_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] sa, input logic [2:0] sbr);
    issue(op, dst, sa, sbr, 1'b0, 3'd0, 16'h0);
    exec_check();
    inst_valid = 1'b0;
    wait_idle();
  endtask

  task automatic check_all_zero();
    for (int i = 0; i < 8; i++) begin
      mrf[i] = 16'h0000;
      run(OP_OR, 3'd0, 3'(i), 3'(i));
    end
  endtask

  initial begin
    rst = 1'b1; inst_valid = 1'b0; inst_op = '0; inst_dst = '0; inst_sa = '0; inst_sb = '0;
    reg_we = 1'b0; reg_waddr = '0; reg_wdata = '0;
    for (int i = 0; i < 8; i++) mrf[i] = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1. Reset / idle state
    @(negedge clk);
    check("rst_ready",   inst_ready, 1'b1);
    check("rst_wbvalid", wb_valid,   1'b0);
    check("rst_aluop",   alu_op,     8'h00);
    check("rst_opa",     alu_a,      16'h0000);
    check("rst_wbdata",  wb_data,    16'h0000);
`ifdef ALU_ISSUE_CMP_FLAG_EN
    check("rst_cmpflag", cmp_flag, 1'b0);
`endif
    check_all_zero();

    // 2. ADD with r2 preloaded in the accepting cycle
    preload(3'd1, 16'h0003);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b1, 3'd2, 16'h0004);
    exec_check();
    inst_valid = 1'b0;
    wait_idle();
    check("add_idle_aluop", alu_op, 8'h00);

    // 3. Wrap and shift boundaries; preload to r0 is ignored
    preload(3'd1, 16'hFFFF);
    preload(3'd2, 16'h0001);
    preload(3'd5, 16'h0010);
    preload(3'd0, 16'h0055);
    run(OP_ADD, 3'd3, 3'd1, 3'd2);
    run(OP_SL,  3'd4, 3'd2, 3'd2);
    run(OP_SR,  3'd6, 3'd1, 3'd5);
    run(OP_OR,  3'd7, 3'd0, 3'd0);
    run(OP_XOR, 3'd7, 3'd1, 3'd5);
    run(OP_NOT, 3'd6, 3'd5, 3'd0);
    run(OP_AND, 3'd4, 3'd7, 3'd1);

    // 4. CMP to r0 and the flag
    preload(3'd1, 16'h1234);
    preload(3'd2, 16'h1234);
    run(OP_CMP, 3'd0, 3'd1, 3'd2);
    run(OP_OR,  3'd7, 3'd0, 3'd0);
`ifdef ALU_ISSUE_CMP_FLAG_EN
    check("cmp_flag_set", cmp_flag, 1'b1);
    run(OP_ADD, 3'd6, 3'd1, 3'd2);
    check("cmp_flag_hold", cmp_flag, 1'b1);
`endif
    run(OP_CMP, 3'd5, 3'd1, 3'd4);
`ifdef ALU_ISSUE_CMP_FLAG_EN
    check("cmp_flag_clr", cmp_flag, 1'b0);
`endif

    // 5. Back-to-back dependent pair, preload during EXEC ignored
    preload(3'd1, 16'h0005);
    preload(3'd2, 16'h0006);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    check("b2b_ready_exec", inst_ready, 1'b0);
    reg_we = 1'b1; reg_waddr = 3'd1; reg_wdata = 16'hBEEF;
    @(negedge clk);
    check("b2b_ready_wb", inst_ready, 1'b0);
    reg_we = 1'b0;
    issue(OP_ADD, 3'd4, 3'd3, 3'd1, 1'b0, 3'd0, 16'h0);
    exec_check();
    inst_valid = 1'b0;
    wait_idle();
    run(OP_OR, 3'd0, 3'd1, 3'd1);

    // 6. Reset during EXEC aborts the instruction
    issue(OP_ADD, 3'd7, 3'd3, 3'd4, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    for (int i = 0; i < 8; i++) mrf[i] = 16'h0000;
    @(negedge clk);
    check("mid_rst_ready",   inst_ready, 1'b1);
    check("mid_rst_wbvalid", wb_valid,   1'b0);
    check("mid_rst_aluop",   alu_op,     8'h00);
    check("mid_rst_wbaddr",  wb_addr,    3'd0);
    check("mid_rst_wbdata",  wb_data,    16'h0000);
`ifdef ALU_ISSUE_CMP_FLAG_EN
    check("mid_rst_cmpflag", cmp_flag, 1'b0);
`endif
    rst = 1'b0; inst_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero();

    // Drain
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
